pipe_if_stage: RTL and testbench
================================

Name: pipe_if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the decode stage.
- Holds the PC, issues fetch requests to instruction memory over a req/ready handshake, and selects next PC from decode's pcsource/bpc/da/jpc.
- Honours decode's wpcir stall, keeps a one-entry skid buffer for instructions returned during a stall, and latches redirects that arrive while a fetch is outstanding.
- Delivers dpc4/inst to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted into IF/ID.

Ports:
- clock  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 da (jr), 11 jpc.
- bpc  in  32  branch target from decode.
- da  in  32  forwarded rs value from decode (jr target).
- jpc  in  32  jump target from decode.
- wpcir  in  1  1 = PC and IF/ID may advance; 0 = decode stall, hold.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (current pc).
- imem_rdata  in  32  fetched instruction, valid when imem_ready=1.
- imem_ready  in  1  fetch completes this cycle (same-cycle response allowed).
- pc  out  32  current fetch PC.
- dpc4  out  32  IF/ID: pc+4 of instruction in decode.
- inst  out  32  IF/ID: instruction in decode.

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC, dpc4=0, inst=NOP_INST.
  - Skid buffer empty, redirect register empty, imem_req=0.
  - FSM=FETCH on first clock after release.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
  - HELD: instruction held in skid buffer, imem_req=0.
- pc4 = pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- npc selection:
  - Redirect register valid: npc = its target.
  - Otherwise: npc = mux(pcsource) of pc4/bpc/da/jpc.
- Fetch-completion source ("avail"):
  - FETCH with imem_ready=1: use imem_rdata.
  - HELD: use the buffer.
- wpcir=1 and avail:
  - IF/ID <= {pc4, instruction}; pc <= npc.
  - Redirect register cleared; buffer emptied; go FETCH.
- wpcir=1 and not avail (memory wait):
  - IF/ID <= {dpc4 unchanged, NOP_INST}; pc holds.
  - If pcsource != 00 and redirect register empty, capture the selected target into the redirect register (decode's branch would otherwise be lost to the bubble).
- wpcir=0:
  - IF/ID and pc hold.
  - pcsource is ignored (decode re-presents it after the stall).
  - If FETCH and imem_ready=1: load buffer, go HELD, drop imem_req next cycle.
- Simultaneous redirect and completion with wpcir=1: pc <= target. The fetched instruction is the delay slot and enters IF/ID (MIPS delay-slot semantics).
- Latency:
  - One cycle from imem_ready to inst at decode.
  - Zero extra bubbles when imem_ready is always 1 and wpcir=1.
- Reset asserted mid-fetch: outstanding response discarded; memory must tolerate the dropped request.

Optional Feature:
- Macro: PIPE_IF_FLUSH_EN.
- Defined: no delay slot.
  - Whenever a redirect is taken (pcsource != 00 with wpcir=1, or redirect register applied), the instruction completing that cycle is squashed: IF/ID inst <= NOP_INST, pc <= target.
  - An instruction in the skid buffer at redirect is discarded.
- Undefined: delay-slot behaviour as above.

Decomposition:
- Shared package pipe_pkg:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11.
  - NOP_INST.
  - IF FSM state encoding (FETCH, HELD).
- One sub-module: pipe_if_npc, the combinational next-PC selector (pcsource mux plus redirect-register override).
- State, skid buffer and IF/ID register live in pipe_if_stage.

Test Plan:
- Reset release, imem_ready=1, wpcir=1, pcsource=00 -> imem_addr 0,4,8,...; dpc4/inst one cycle behind (dpc4=4 with word@0).
- At pc=0x10, pcsource=01, bpc=0x40 -> delay slot from 0x10 enters IF/ID, next imem_addr=0x40; with PIPE_IF_FLUSH_EN, inst=NOP_INST instead.
- imem_ready=0 for 3 cycles while pcsource=11, jpc=0x100 -> three NOP bubbles, pc held, then completion and next imem_addr=0x100.
- wpcir=0 for 2 cycles, imem_ready=1 in first -> HELD, imem_req=0, inst/dpc4 unchanged; wpcir=1 -> buffered word enters IF/ID, no refetch.
- pc=0xFFFF_FFFC, pcsource=00 -> dpc4=0, next pc=0.
- resetn pulsed low mid-wait -> pc=RESET_PC, inst=NOP_INST immediately, redirect register cleared.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: next-PC select codes,
// the bubble instruction, and the fetch-stage state encoding.
package pipe_pkg;

   // next-PC select codes driven by decode
   localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc+4
   localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
   localparam logic [1:0] PCSRC_JR  = 2'b10;  // register target (jr)
   localparam logic [1:0] PCSRC_J   = 2'b11;  // jump target

   // sll $0,$0,0 -- the canonical bubble
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   // fetch-stage states
   typedef enum logic {
      IF_FETCH = 1'b0,   // request outstanding at pc
      IF_HELD  = 1'b1    // fetched word parked in the skid buffer
   } if_state_t;

endpackage

// File: rtl/pipe_if_npc.sv
// Combinational next-PC selector for the fetch stage. A latched redirect
// (captured while a fetch was still outstanding) overrides decode's current
// select, since decode has already moved on by the time the fetch lands.
module pipe_if_npc
(
   input  logic [1:0]  pcsource,
   input  logic [31:0] pc4,
   input  logic [31:0] bpc,
   input  logic [31:0] da,
   input  logic [31:0] jpc,
   input  logic        rdr_vld,
   input  logic [31:0] rdr_tgt,
   output logic [31:0] sel_tgt,
   output logic [31:0] npc
);
   import pipe_pkg::*;

   // target chosen by decode this cycle
   always_comb begin
      sel_tgt = pc4;
      case (pcsource)
         PCSRC_SEQ: sel_tgt = pc4;
         PCSRC_BR:  sel_tgt = bpc;
         PCSRC_JR:  sel_tgt = da;
         PCSRC_J:   sel_tgt = jpc;
         default:   sel_tgt = pc4;
      endcase
   end

   // a pending redirect wins over decode's current select
   assign npc = rdr_vld ? rdr_tgt : sel_tgt;

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage plus IF/ID register of the 5-stage MIPS pipeline.
// Owns the PC, talks to instruction memory over req/ready, parks a word that
// returns during a decode stall in a one-entry skid buffer, and remembers a
// redirect that decode issued while a fetch was still outstanding.
// Optional build macro PIPE_IF_FLUSH_EN: removes the branch delay slot by
// squashing the instruction that completes in the cycle a redirect is taken.
module pipe_if_stage
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
)
(
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] da,
   input  logic [31:0] jpc,
   input  logic        wpcir,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] dpc4,
   output logic [31:0] inst
);
   import pipe_pkg::*;

   if_state_t   state;
   logic [31:0] skid_q;     // word returned while decode was stalled
   logic        rdr_vld;    // redirect waiting for the outstanding fetch
   logic [31:0] rdr_tgt;

   logic [31:0] pc4;
   logic [31:0] sel_tgt;
   logic [31:0] npc;
   logic        held;
   logic        avail;
   logic [31:0] fetch_word;
   logic        squash;

   assign pc4        = pc + 32'd4;   // natural 32-bit wrap
   assign held       = (state == IF_HELD);
   // imem_req is low only in the first cycle after reset or while HELD, so a
   // ready with no request outstanding is ignored
   assign avail      = held | (imem_req & imem_ready);
   assign fetch_word = held ? skid_q : imem_rdata;
   assign imem_addr  = pc;

`ifdef PIPE_IF_FLUSH_EN
   // no delay slot: whatever completes alongside a redirect is dropped
   assign squash = rdr_vld | (pcsource != PCSRC_SEQ);
`else
   // delay-slot semantics: the completing instruction always enters decode
   assign squash = 1'b0;
`endif

   pipe_if_npc u_npc (
      .pcsource (pcsource),
      .pc4      (pc4),
      .bpc      (bpc),
      .da       (da),
      .jpc      (jpc),
      .rdr_vld  (rdr_vld),
      .rdr_tgt  (rdr_tgt),
      .sel_tgt  (sel_tgt),
      .npc      (npc)
   );

   // fetch FSM, PC, skid buffer, redirect latch and IF/ID register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IF_FETCH;
         imem_req <= 1'b0;
         pc       <= RESET_PC;
         dpc4     <= 32'h0000_0000;
         inst     <= NOP_INST;
         skid_q   <= 32'h0000_0000;
         rdr_vld  <= 1'b0;
         rdr_tgt  <= 32'h0000_0000;
      end else if (wpcir) begin
         if (avail) begin
            // instruction delivered to decode, pc advances to the chosen target
            dpc4     <= pc4;
            inst     <= squash ? NOP_INST : fetch_word;
            pc       <= npc;
            rdr_vld  <= 1'b0;
            state    <= IF_FETCH;
            imem_req <= 1'b1;
         end else begin
            // memory wait: bubble into decode, keep pc and keep requesting
            inst     <= NOP_INST;
            imem_req <= 1'b1;
            // decode sees the bubble next cycle and will stop presenting its
            // branch, so hold on to the target here
            if ((pcsource != PCSRC_SEQ) && !rdr_vld) begin
               rdr_vld <= 1'b1;
               rdr_tgt <= sel_tgt;
            end
         end
      end else if (!held) begin
         // decode stall: pc and IF/ID hold, pcsource is not acted on
         if (imem_req && imem_ready) begin
            skid_q   <= imem_rdata;
            state    <= IF_HELD;
            imem_req <= 1'b0;
         end else begin
            imem_req <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage. Instruction memory returns addr^8C000000
// combinationally; every expectation below is a hand-computed constant.
module tb_pipe_if_stage;

`ifdef PIPE_IF_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        resetn;
   logic [1:0]  pcsource;
   logic [31:0] bpc, da, jpc;
   logic        wpcir;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc, dpc4, inst;

   int checks = 0;
   int errors = 0;

   pipe_if_stage dut (
      .clock      (clock),
      .resetn     (resetn),
      .pcsource   (pcsource),
      .bpc        (bpc),
      .da         (da),
      .jpc        (jpc),
      .wpcir      (wpcir),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .pc         (pc),
      .dpc4       (dpc4),
      .inst       (inst)
   );

   always #5 clock = ~clock;

   // memory model
   always_comb imem_rdata = imem_addr ^ 32'h8C00_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_dpc4, input logic [31:0] e_inst);
      chk({tag, ".pc"},   pc,   e_pc);
      chk({tag, ".dpc4"}, dpc4, e_dpc4);
      chk({tag, ".inst"}, inst, e_inst);
   endtask

   initial begin
      resetn = 1'b0; pcsource = 2'b00; bpc = '0; da = 32'h0000_0DA0; jpc = '0;
      wpcir = 1'b1; imem_ready = 1'b1;
      tick; tick;
      chk_if("reset", 32'h0, 32'h0, NOP);
      chk("reset.req", {31'b0, imem_req}, 32'h0);

      // release: first clock raises the request at pc 0
      resetn = 1'b1;
      tick;
      chk("first.req", {31'b0, imem_req}, 32'h1);
      chk("first.addr", imem_addr, 32'h0);
      chk_if("first", 32'h0, 32'h0, NOP);

      // sequential stream, one instruction per cycle
      tick; chk_if("seq0", 32'h4,  32'h4,  32'h8C00_0000);
      tick; chk_if("seq1", 32'h8,  32'h8,  32'h8C00_0004);
      tick; chk_if("seq2", 32'hC,  32'hC,  32'h8C00_0008);
      tick; chk_if("seq3", 32'h10, 32'h10, 32'h8C00_000C);

      // branch at 0x10 to 0x40: word at 0x10 is the delay slot
      pcsource = 2'b01; bpc = 32'h40;
      tick;
      chk_if("br", 32'h40, 32'h14, FLUSH ? NOP : 32'h8C00_0010);
      chk("br.addr", imem_addr, 32'h40);
      pcsource = 2'b00;
      tick; chk_if("br.tgt", 32'h44, 32'h44, 32'h8C00_0040);

      // jump during a 3-cycle memory wait
      imem_ready = 1'b0; pcsource = 2'b11; jpc = 32'h100;
      tick; chk_if("wait0", 32'h44, 32'h44, NOP);
      pcsource = 2'b00;
      tick; chk_if("wait1", 32'h44, 32'h44, NOP);
      tick; chk_if("wait2", 32'h44, 32'h44, NOP);
      imem_ready = 1'b1;
      tick;
      chk_if("wait.done", 32'h100, 32'h48, FLUSH ? NOP : 32'h8C00_0044);
      chk("wait.addr", imem_addr, 32'h100);
      tick; chk_if("jtgt", 32'h104, 32'h104, 32'h8C00_0100);

      // decode stall: word lands in skid buffer, request drops
      wpcir = 1'b0;
      tick;
      chk_if("stall0", 32'h104, 32'h104, 32'h8C00_0100);
      chk("stall0.req", {31'b0, imem_req}, 32'h0);
      imem_ready = 1'b0;
      tick;
      chk_if("stall1", 32'h104, 32'h104, 32'h8C00_0100);
      chk("stall1.req", {31'b0, imem_req}, 32'h0);
      // release with memory not ready: buffered word must be used
      wpcir = 1'b1;
      tick;
      chk_if("unstall", 32'h108, 32'h108, 32'h8C00_0104);
      chk("unstall.req", {31'b0, imem_req}, 32'h1);

      // jump to the top word, then wrap to 0
      imem_ready = 1'b1; pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
      tick; chk_if("jtop", 32'hFFFF_FFFC, 32'h10C, FLUSH ? NOP : 32'h8C00_0108);
      pcsource = 2'b00;
      tick; chk_if("wrap", 32'h0, 32'h0, 32'h73FF_FFFC);
      tick; chk_if("wrap1", 32'h4, 32'h4, 32'h8C00_0000);

      // branch captured during a wait, then reset mid-wait
      imem_ready = 1'b0; pcsource = 2'b01; bpc = 32'h200;
      tick; chk_if("rwait", 32'h4, 32'h4, NOP);
      resetn = 1'b0;
      #2;
      chk_if("midrst", 32'h0, 32'h0, NOP);
      chk("midrst.req", {31'b0, imem_req}, 32'h0);
      resetn = 1'b1; pcsource = 2'b00; imem_ready = 1'b1;
      tick; chk_if("post0", 32'h0, 32'h0, NOP);
      // redirect to 0x200 must have been cleared by reset
      tick; chk_if("post1", 32'h4, 32'h4, 32'h8C00_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
